// File: rtl/mb_sched_pkg.sv
// -----------------------------------------------------------------------------
// mb_sched_pkg
// Shared definitions for the round-robin multiplier scheduler:
//   MUL_LAT   issue-to-product latency of mb16_td (input reg + output reg)
//   NREQ_MAX  largest supported requester count
//   TAG_IDW   ID width carried in the tag pipe (wide enough for NREQ_MAX)
//   IDW_OF()  requester-ID width for a given requester count
//   mul_tag_t one tag-pipe stage: valid bit plus originating requester ID
//   rr_pick() one-hot round-robin pick starting at a pointer
// -----------------------------------------------------------------------------
package mb_sched_pkg;

  localparam int MUL_LAT  = 2;
  localparam int NREQ_MAX = 8;
  localparam int TAG_IDW  = 3;

  function automatic int IDW_OF(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic               v;
    logic [TAG_IDW-1:0] id;
  } mul_tag_t;

  // Scan req from ptr upward, wrapping modulo n; the first set bit wins.
  // Bits at or above n are never looked at.
  function automatic logic [NREQ_MAX-1:0] rr_pick(input logic [NREQ_MAX-1:0] req,
                                                  input logic [TAG_IDW-1:0]  ptr,
                                                  input int                  n);
    logic [NREQ_MAX-1:0] gnt;
    logic                found;
    logic [TAG_IDW-1:0]  idx;
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ_MAX; k++) begin
      if (k < n) begin
        idx = TAG_IDW'((int'(ptr) + k) % n);
        if (!found && req[idx]) begin
          gnt[idx] = 1'b1;
          found    = 1'b1;
        end
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/mb16_rr_sched_if.sv
// -----------------------------------------------------------------------------
// mb16_rr_sched_if
// Requester and result bus of the shared-multiplier scheduler.
//   req_valid   requester i has an operand pair
//   req_mx/my   operands, requester i at [i*WIDTH +: WIDTH]
//   req_ready   one-hot accept of requester i this cycle
//   res_valid   single-cycle product pulse
//   res_id      originating requester of res_product
//   res_product signed 2*WIDTH product
//   inflight    ops issued but not yet returned
//   sched_en    0 stops new issues; in-flight ops still complete
// master = requesters/consumer side, slave = scheduler side.
// -----------------------------------------------------------------------------
interface mb16_rr_sched_if #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_mx;
  logic [NREQ*WIDTH-1:0] req_my;
  logic [NREQ-1:0]       req_ready;
  logic                  res_valid;
  logic [IDW-1:0]        res_id;
  logic [2*WIDTH-1:0]    res_product;
  logic [IDW:0]          inflight;
  logic                  sched_en;

  modport master (
    output req_valid, req_mx, req_my, sched_en,
    input  req_ready, res_valid, res_id, res_product, inflight
  );

  modport slave (
    input  req_valid, req_mx, req_my, sched_en,
    output req_ready, res_valid, res_id, res_product, inflight
  );

endinterface

// File: rtl/mb16_td.sv
// -----------------------------------------------------------------------------
// mb16_td
// Registered signed radix-4 Booth multiplier, two cycles issue-to-product:
// operands are captured when en=1 (held otherwise), the product of the held
// operands is registered on the following edge.
//   CLK      clock
//   en       capture mx/my this edge
//   mx, my   two's-complement operands
//   product  registered full-width signed product
// -----------------------------------------------------------------------------
module mb16_td #(
  parameter int WIDTH = 16
) (
  input  logic                      CLK,
  input  logic                      en,
  input  logic signed [WIDTH-1:0]   mx,
  input  logic signed [WIDTH-1:0]   my,
  output logic signed [2*WIDTH-1:0] product
);

  logic signed [WIDTH-1:0]   mx_q;
  logic signed [WIDTH-1:0]   my_q;
  logic signed [2*WIDTH-1:0] mx_ext;
  logic        [WIDTH:0]     y_ext;
  logic        [2:0]         grp;
  logic signed [2*WIDTH-1:0] pp;
  logic signed [2*WIDTH-1:0] pp_sum;

  // NOTE: the datapath registers carry no reset; the scheduler's tag valids
  // decide whether their contents mean anything.
  always_ff @(posedge CLK) begin
    if (en) begin
      mx_q <= mx;
      my_q <= my;
    end
    product <= pp_sum;
  end

  // Each overlapping 3-bit group of {my, 0} selects a digit in {-2..2};
  // the digit's multiple of mx is weighted by 4^i.
  always_comb begin
    mx_ext = {{WIDTH{mx_q[WIDTH-1]}}, mx_q};
    y_ext  = {my_q, 1'b0};
    grp    = '0;
    pp     = '0;
    pp_sum = '0;
    for (int i = 0; i < WIDTH / 2; i++) begin
      grp = y_ext[2*i +: 3];
      case (grp)
        3'b001, 3'b010: pp = mx_ext;
        3'b011:         pp = mx_ext <<< 1;
        3'b100:         pp = -(mx_ext <<< 1);
        3'b101, 3'b110: pp = -mx_ext;
        default:        pp = '0;
      endcase
      pp_sum = pp_sum + (pp <<< (2 * i));
    end
  end

endmodule

// File: rtl/rr_arb.sv
// -----------------------------------------------------------------------------
// rr_arb
// NREQ-wide round-robin picker with its pointer register. The pointer moves
// to one past the winner on every grant and holds otherwise.
//   CLK        clock
//   RST        synchronous reset, active low (pointer -> 0)
//   en         grant enable (already qualified with reset by the parent)
//   req        request vector
//   grant      one-hot grant, never set where req is 0
//   grant_id   binary index of the granted requester
//   grant_any  a grant is issued this cycle
// -----------------------------------------------------------------------------
module rr_arb
  import mb_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = IDW_OF(NREQ)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id,
  output logic            grant_any
);

  logic [IDW-1:0]      ptr;
  logic [NREQ_MAX-1:0] req_ext;
  logic [NREQ_MAX-1:0] pick;
  logic                unused_pick;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    req_ext            = '0;
    req_ext[NREQ-1:0]  = req;
    pick               = rr_pick(req_ext, TAG_IDW'(ptr), NREQ);
    grant              = en ? pick[NREQ-1:0] : '0;
    grant_id           = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) grant_id = IDW'(i);
    end
  end

  assign grant_any   = |grant;
  assign unused_pick = ^pick;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      ptr <= '0;
    end else if (grant_any) begin
      ptr <= (int'(grant_id) == NREQ - 1) ? '0 : grant_id + IDW'(1);
    end
  end

endmodule

// File: rtl/mb16_rr_sched.sv
// -----------------------------------------------------------------------------
// mb16_rr_sched
// Round-robin scheduler sharing one mb16_td among NREQ requesters. At most
// one operand pair is issued per cycle; a tag pipe running alongside the
// multiplier returns each product with its requester ID, in issue order,
// MUL_LAT+1 edges after the grant.
//   CLK   clock
//   RST   synchronous reset, active low; discards everything in flight
//   bus   mb16_rr_sched_if slave: requester handshakes, result, inflight,
//         sched_en
// -----------------------------------------------------------------------------
module mb16_rr_sched
  import mb_sched_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  parameter int IDW   = IDW_OF(NREQ)
) (
  input logic             CLK,
  input logic             RST,
  mb16_rr_sched_if.slave  bus
);

  logic [NREQ-1:0]           grant;
  logic [IDW-1:0]            grant_id;
  logic                      grant_any;
  logic signed [WIDTH-1:0]   mul_mx;
  logic signed [WIDTH-1:0]   mul_my;
  logic signed [2*WIDTH-1:0] mul_product;
  mul_tag_t                  tag_in;
  mul_tag_t                  tag_q [MUL_LAT];
  logic                      res_valid_q;
  logic [IDW-1:0]            res_id_q;
  logic [2*WIDTH-1:0]        res_product_q;
  logic [IDW:0]              inflight_q;
  logic                      unused_tag;

  // Reset is folded into the enable so req_ready is 0 while RST is low.
  rr_arb #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .CLK       (CLK),
    .RST       (RST),
    .en        (bus.sched_en & RST),
    .req       (bus.req_valid),
    .grant     (grant),
    .grant_id  (grant_id),
    .grant_any (grant_any)
  );

  assign bus.req_ready = grant;

  always_comb begin
    mul_mx = '0;
    mul_my = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        mul_mx = bus.req_mx[i*WIDTH +: WIDTH];
        mul_my = bus.req_my[i*WIDTH +: WIDTH];
      end
    end
    tag_in.v  = grant_any;
    tag_in.id = TAG_IDW'(grant_id);
  end

  // Without a grant the multiplier keeps its previous operands.
  mb16_td #(
    .WIDTH (WIDTH)
  ) u_mul (
    .CLK     (CLK),
    .en      (grant_any),
    .mx      (mul_mx),
    .my      (mul_my),
    .product (mul_product)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int k = 0; k < MUL_LAT; k++) tag_q[k] <= '0;
      res_valid_q   <= 1'b0;
      res_id_q      <= '0;
      res_product_q <= '0;
      inflight_q    <= '0;
    end else begin
      tag_q[0] <= tag_in;
      for (int k = 1; k < MUL_LAT; k++) tag_q[k] <= tag_q[k-1];
      res_valid_q <= tag_q[MUL_LAT-1].v;
      res_id_q    <= tag_q[MUL_LAT-1].id[IDW-1:0];
      // Only load products that belong to a real op, so idle cycles never
      // expose the unreset multiplier registers.
      if (tag_q[MUL_LAT-1].v) res_product_q <= mul_product;
      case ({grant_any, res_valid_q})
        2'b10:   inflight_q <= inflight_q + (IDW+1)'(1);
        2'b01:   inflight_q <= inflight_q - (IDW+1)'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  assign unused_tag = ^tag_q[MUL_LAT-1].id;

  assign bus.res_valid   = res_valid_q;
  assign bus.res_id      = res_id_q;
  assign bus.res_product = res_product_q;
  assign bus.inflight    = inflight_q;

endmodule

// File: tb/tb_mb16_rr_sched.sv
// -----------------------------------------------------------------------------
// tb_mb16_rr_sched
// Directed bench for mb16_rr_sched. An issue monitor pushes the expected
// {id, product, issue cycle} for every accepted pair into a scoreboard; a
// result monitor pops and compares on every res_valid pulse, including the
// grant-to-result latency. Stimulus also checks grant order directly.
// -----------------------------------------------------------------------------
module tb_mb16_rr_sched;

  localparam int WIDTH = 16;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic CLK;
  logic RST;

  mb16_rr_sched_if #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) bus ();

  mb16_rr_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int          id;
    logic [31:0] prod;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_prod [NREQ];
  int          cyc     = 0;
  int          n_tests = 0;
  int          n_fail  = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Issue monitor: record what each accepted pair must produce.
  always @(negedge CLK) begin
    if ((|bus.req_ready) === 1'b1) begin
      check("ready_implies_valid", bus.req_ready & ~bus.req_valid, 0);
      check("ready_onehot", $countones(bus.req_ready), 1);
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_ready[i]) sb.push_back('{i, exp_prod[i], cyc});
      end
    end
  end

  // Result monitor: every pulse must match the oldest outstanding op.
  always @(negedge CLK) begin : mon_res
    exp_t e;
    if (bus.res_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_res: got id %0d product 0x%0h, want no result",
                 bus.res_id, bus.res_product);
      end else begin
        e = sb.pop_front();
        check("res_id", bus.res_id, e.id);
        check("res_product", bus.res_product, e.prod);
        check("res_latency", cyc - e.cyc, 3);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_op(input int i, input logic signed [15:0] mx,
                        input logic signed [15:0] my, input logic [31:0] p);
    bus.req_mx[i*WIDTH +: WIDTH] = mx;
    bus.req_my[i*WIDTH +: WIDTH] = my;
    exp_prod[i] = p;
  endtask

  task automatic expect_grant(input string name, input logic [NREQ-1:0] exp);
    @(negedge CLK);
    check(name, bus.req_ready, exp);
    step();
  endtask

  task automatic drain(input string name);
    int k = 0;
    while ((sb.size() != 0 || bus.inflight != 0) && k < 20) begin
      step();
      k++;
    end
    check({name, "_pending"}, sb.size(), 0);
    check({name, "_inflight"}, bus.inflight, 0);
  endtask

  logic [NREQ-1:0] t3_order [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                    4'b0001, 4'b0010, 4'b0100, 4'b1000};

  initial begin
    RST          = 1'b0;
    bus.req_valid = '0;
    bus.req_mx    = '0;
    bus.req_my    = '0;
    bus.sched_en  = 1'b1;
    for (int i = 0; i < NREQ; i++) exp_prod[i] = '0;

    // 1. Reset held with every requester asking.
    bus.req_valid = '1;
    step();
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check("rst_ready", bus.req_ready, 0);
      check("rst_res_valid", bus.res_valid, 0);
      check("rst_inflight", bus.inflight, 0);
      step();
    end
    bus.req_valid = '0;
    RST = 1'b1;
    step();

    // 2. Single op: 3 * -5.
    set_op(0, 16'sd3, -16'sd5, 32'hFFFF_FFF1);
    bus.req_valid = 4'b0001;
    expect_grant("t2_grant", 4'b0001);
    bus.req_valid = '0;
    drain("t2");

    // 3. Full contention from a fresh pointer.
    RST = 1'b0;
    step();
    RST = 1'b1;
    set_op(0, 16'sd1, 16'sd10, 32'd10);
    set_op(1, 16'sd2, 16'sd10, 32'd20);
    set_op(2, 16'sd3, 16'sd10, 32'd30);
    set_op(3, 16'sd4, 16'sd10, 32'd40);
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      check("t3_grant", bus.req_ready, t3_order[k]);
      if (k >= 3) check("t3_inflight", bus.inflight, 3);
      step();
    end
    bus.req_valid = '0;
    drain("t3");

    // 4. Wrap: move pointer to 3 via req2, then only req0/req3 ask.
    set_op(2, 16'sd7, -16'sd6, 32'hFFFF_FFD6);
    bus.req_valid = 4'b0100;
    expect_grant("t4_setup", 4'b0100);
    set_op(0, 16'sd5, 16'sd5, 32'd25);
    set_op(3, -16'sd2, 16'sd100, 32'hFFFF_FF38);
    bus.req_valid = 4'b1001;
    expect_grant("t4_wrap_a", 4'b1000);
    expect_grant("t4_wrap_b", 4'b0001);
    expect_grant("t4_wrap_c", 4'b1000);
    bus.req_valid = '0;
    drain("t4");

    // 5. Extreme operands from req1, back to back.
    set_op(1, -16'sd32768, -16'sd32768, 32'h4000_0000);
    bus.req_valid = 4'b0010;
    expect_grant("t5_grant_a", 4'b0010);
    set_op(1, 16'sd32767, -16'sd32768, 32'hC000_8000);
    expect_grant("t5_grant_b", 4'b0010);
    bus.req_valid = '0;
    drain("t5");

    // sched_en drop with two ops in flight; pointer (2) must stay frozen.
    set_op(0, -16'sd1, -16'sd1, 32'd1);
    set_op(1, 16'sd100, 16'sd200, 32'h0000_4E20);
    bus.req_valid = 4'b0011;
    expect_grant("en_grant_a", 4'b0001);
    expect_grant("en_grant_b", 4'b0010);
    bus.sched_en = 1'b0;
    for (int k = 0; k < 4; k++) expect_grant("en_off_ready", 4'b0000);
    drain("en_off");
    bus.sched_en = 1'b1;
    expect_grant("en_resume", 4'b0001);
    bus.req_valid = '0;
    drain("en_on");

    // 6. Reset one cycle before the first of two results (pointer is 1).
    set_op(0, 16'sd11, 16'sd11, 32'd121);
    set_op(1, -16'sd3, 16'sd4, 32'hFFFF_FFF4);
    bus.req_valid = 4'b0011;
    expect_grant("t6_grant_a", 4'b0010);
    expect_grant("t6_grant_b", 4'b0001);
    RST = 1'b0;
    sb.delete();
    @(negedge CLK);
    check("t6_rst_ready", bus.req_ready, 0);
    step();
    RST = 1'b1;
    bus.req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      check("t6_inflight", bus.inflight, 0);
      step();
    end
    set_op(0, 16'sd9, -16'sd9, 32'hFFFF_FFAF);
    bus.req_valid = 4'b1111;
    expect_grant("t6_ptr_zero", 4'b0001);
    bus.req_valid = '0;
    drain("t6");

    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
